multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath; replaces the single-cycle opcode decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states over a shared instruction/data memory port with a ready handshake.
- Drives all datapath mux selects and write enables.
- Keeps a retired-instruction counter for bring-up and performance checks.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- opcode  input  7  instr[6:0] taken from the instruction register (valid from DECODE on).
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- PCWr  output  1  PC register write enable.
- IRWr  output  1  instruction register write enable.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWr  output  1  memory write request.
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = memory data register.
- RegWr  output  1  register file write enable.
- ALUSrcA  output  1  ALU A operand select: 0 = oldPC, 1 = rs1.
- ALUSrcB  output  2  ALU B operand select: 00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp  output  2  ALU operation: 00 = add, 01 = subtract (branch compare), 10 = decode by funct fields.
- PCSrc  output  1  PC next-value select: 0 = ALU result, 1 = ALUOut (branch target).
- retire  output  1  one-cycle pulse when an instruction completes.
- instret  output  CNT_W  retired-instruction count.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Opcodes: LOAD = 0000011, STORE = 0100011, RTYPE = 0110011, ITYPE = 0010011, BEQ = 1100011.
- Reset: state = FETCH, instret = 0, illegal = 0.
- All outputs are decoded from the state and default to 0, except in FETCH, where MemRead = 1 and IorD = 0 (also true while n_rst is low).
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00.
  - While mem_ready = 0: stay in FETCH; PCWr = 0, IRWr = 0.
  - When mem_ready = 1: IRWr = 1 and PCWr = 1 in that same cycle, then go to DECODE.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target latched into ALUOut).
  - Next state by opcode: LOAD/STORE -> MEMADR, RTYPE -> EXEC_R, ITYPE -> EXEC_I, BEQ -> BRANCH.
  - Any other opcode: see the optional feature.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD:
  - IorD = 1, MemRead = 1, held until mem_ready = 1, then go to WB_MEM.
- WB_MEM: RegWr = 1, MemtoReg = 1, retire = 1, then go to FETCH.
- MEM_WR:
  - IorD = 1, MemWr = 1, held until mem_ready = 1.
  - In the mem_ready cycle: retire = 1, then go to FETCH.
  - MemWr must not deassert before mem_ready is seen.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10, then go to WB_ALU.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10, then go to WB_ALU.
- WB_ALU: RegWr = 1, MemtoReg = 0, retire = 1, then go to FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 1.
  - PCWr = zero (combinational, same cycle).
  - retire = 1, then go to FETCH.
- Latency with zero-wait memory: BEQ 3 cycles, RTYPE/ITYPE/STORE 4 cycles, LOAD 5 cycles.
- Each mem_ready wait cycle adds one cycle to these figures.
- At most one of MemRead and MemWr is high in any cycle. RegWr and MemWr are never high together.
- instret increments by 1 on every cycle with retire = 1 and wraps from all-ones to 0.
- Reset asserted mid-instruction: state returns to FETCH immediately and asynchronously; no partial write completes after reset.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all enables to 0 and sets illegal = 1.
  - TRAP is held until reset; no retire is issued.
- Undefined:
  - An unrecognised opcode is treated as a NOP: retire = 1 in DECODE, then go to FETCH.
  - illegal is tied to 0.

Test Plan:
- Reset, then mem_ready held at 1, opcode = 0110011 -> states FETCH, DECODE, EXEC_R, WB_ALU; RegWr pulses in cycle 4; instret = 1.
- LOAD with mem_ready low for 2 cycles in MEM_RD -> MemRead and IorD = 1 held for 3 cycles; WB_MEM asserts RegWr = 1 and MemtoReg = 1; 7 cycles total.
- BEQ with zero = 1, then BEQ with zero = 0 -> PCWr = 1 only in the first BRANCH cycle; PCSrc = 1 in both; each takes 3 cycles.
- STORE with mem_ready = 0 for 3 cycles -> MemWr stays high for 4 cycles; RegWr is never asserted; retire pulses in the mem_ready cycle.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN, illegal = 1 and the FSM stays in TRAP for 10+ cycles; without it, retire pulses in DECODE and the next fetch starts.
- n_rst pulsed low during MEM_WR; separately, CNT_W = 4 with 16 retirements -> after reset, MemWr = 0, state = FETCH, instret = 0; the 16 retirements wrap instret to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWr;
    logic       IRWr;
    logic       IorD;
    logic       MemRead;
    logic       MemWr;
    logic       MemtoReg;
    logic       RegWr;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       PCSrc;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWr, IRWr, IorD, MemRead, MemWr, MemtoReg, RegWr,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWr, IRWr, IorD, MemRead, MemWr, MemtoReg, RegWr,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback over a shared memory port.
// Build option ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal) instead of retiring as NOP.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    multicycle_ctrl_if.master bus,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_TRAP
    } state_e;

    state_e state_q, state_d;

    // State register; reset lands in FETCH so the fetch read request is up during reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and state-decoded datapath controls.
    always_comb begin
        state_d      = state_q;
        bus.PCWr     = 1'b0;
        bus.IRWr     = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWr    = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWr    = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.PCSrc    = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    bus.PCWr = 1'b1;
                    bus.IRWr = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BEQ:            state_d = S_BRANCH;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                bus.RegWr    = 1'b1;
                bus.MemtoReg = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                bus.IorD  = 1'b1;
                bus.MemWr = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = S_WB_ALU;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 2'b10;
                state_d     = S_WB_ALU;
            end
            S_WB_ALU: begin
                bus.RegWr = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b01;
                bus.PCSrc   = 1'b1;
                bus.PCWr    = bus.zero;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Retired-instruction counter, wraps naturally at CNT_W bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky flag, set on the DECODE->TRAP transition and cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                         illegal <= 1'b0;
        else if (state_q == S_DECODE && state_d == S_TRAP)  illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control vectors are queued
// with the stimulus and compared as the DUT steps; a 4-bit counter instance checks wrap.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef enum int { P_F, P_D, P_DNOP, P_MA, P_MR, P_WM, P_MW, P_XR, P_XI, P_WA, P_BR, P_TRAP } phase_e;

    typedef struct packed {
        logic       pcwr, irwr, iord, memread, memwr, memtoreg, regwr, alusrca;
        logic [1:0] alusrcb, aluop;
        logic       pcsrc, retire, illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [6:0]  opcode;
    logic        zero, mem_ready;
    logic        retire, illegal, retire4, illegal4;
    logic [31:0] instret;
    logic [3:0]  instret4;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus4 ();
    assign bus.opcode     = opcode;
    assign bus.zero       = zero;
    assign bus.mem_ready  = mem_ready;
    assign bus4.opcode    = opcode;
    assign bus4.zero      = zero;
    assign bus4.mem_ready = mem_ready;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .retire(retire), .instret(instret), .illegal(illegal));
    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .bus(bus4), .retire(retire4), .instret(instret4), .illegal(illegal4));

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_cnt = 0;
    bit          q_rdy[$];
    bit          q_z[$];
    ctl_t        q_exp[$];

    // Expected control vector for one cycle in a given phase.
    function automatic ctl_t expv(phase_e p, bit rdy, bit z);
        ctl_t e = '0;
        case (p)
            P_F:    begin e.memread = 1; e.alusrcb = 2'b01; e.pcwr = rdy; e.irwr = rdy; end
            P_D:    e.alusrcb = 2'b10;
            P_DNOP: begin e.alusrcb = 2'b10; e.retire = 1; end
            P_MA:   begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MR:   begin e.iord = 1; e.memread = 1; end
            P_WM:   begin e.regwr = 1; e.memtoreg = 1; e.retire = 1; end
            P_MW:   begin e.iord = 1; e.memwr = 1; e.retire = rdy; end
            P_XR:   begin e.alusrca = 1; e.aluop = 2'b10; end
            P_XI:   begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b10; end
            P_WA:   begin e.regwr = 1; e.retire = 1; end
            P_BR:   begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 1; e.pcwr = z; e.retire = 1; end
            P_TRAP: e.illegal = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic add(input phase_e p, input bit rdy, input bit z);
        q_rdy.push_back(rdy);
        q_z.push_back(z);
        q_exp.push_back(expv(p, rdy, z));
    endtask

    task automatic build_instr(input logic [6:0] op, input bit z, input int fw, input int mw);
        for (int i = 0; i < fw; i++) add(P_F, 1'b0, z);
        add(P_F, 1'b1, z);
        case (op)
            OP_LOAD:  begin add(P_D, 1, z); add(P_MA, 1, z);
                            for (int i = 0; i < mw; i++) add(P_MR, 1'b0, z);
                            add(P_MR, 1, z); add(P_WM, 1, z); end
            OP_STORE: begin add(P_D, 1, z); add(P_MA, 1, z);
                            for (int i = 0; i < mw; i++) add(P_MW, 1'b0, z);
                            add(P_MW, 1, z); end
            OP_RTYPE: begin add(P_D, 1, z); add(P_XR, 1, z); add(P_WA, 1, z); end
            OP_ITYPE: begin add(P_D, 1, z); add(P_XI, 1, z); add(P_WA, 1, z); end
            OP_BEQ:   begin add(P_D, 1, z); add(P_BR, 1, z); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                add(P_D, 1, z);
                for (int i = 0; i < 12; i++) add(P_TRAP, 1, z);
`else
                add(P_DNOP, 1, z);
`endif
            end
        endcase
    endtask

    // Apply queued stimulus cycle by cycle; sample at the falling edge.
    task automatic drain(input string tag);
        ctl_t e, g;
        int   n = 0;
        while (q_exp.size() > 0) begin
            mem_ready = q_rdy.pop_front();
            zero      = q_z.pop_front();
            e         = q_exp.pop_front();
            @(negedge clk);
            g = {bus.PCWr, bus.IRWr, bus.IorD, bus.MemRead, bus.MemWr, bus.MemtoReg, bus.RegWr,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, retire, illegal};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cyc%0d ctl got=%h want=%h", tag, n, g, e);
            end
            checks++;
            if (retire4 !== e.retire) begin
                errors++;
                $display("FAIL %s cyc%0d retire4 got=%b want=%b", tag, n, retire4, e.retire);
            end
            if (e.retire) model_cnt++;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input bit z, input int fw, input int mw, input string tag);
        opcode = op;
        build_instr(op, z, fw, mw);
        drain(tag);
        checks++;
        if (instret !== model_cnt || instret4 !== model_cnt[3:0]) begin
            errors++;
            $display("FAIL %s instret got=%0d/%0d want=%0d", tag, instret, instret4, model_cnt);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        model_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ctl_t e, g;
        n_rst = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_RTYPE;
        #2;
        e = expv(P_F, 1'b0, 1'b0);
        g = {bus.PCWr, bus.IRWr, bus.IorD, bus.MemRead, bus.MemWr, bus.MemtoReg, bus.RegWr,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, retire, illegal};
        checks++;
        if (g !== e) begin errors++; $display("FAIL reset ctl got=%h want=%h", g, e); end
        checks++;
        if (instret !== 32'd0 || instret4 !== 4'd0) begin
            errors++; $display("FAIL reset instret got=%0d/%0d want=0", instret, instret4);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run_instr(OP_RTYPE, 1'b0, 0, 0, "rtype");
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL rtype_count got=%0d want=1", instret); end
    endtask

    task automatic test_load_wait();
        run_instr(OP_LOAD, 1'b0, 0, 2, "load_wait");
    endtask

    task automatic test_beq();
        run_instr(OP_BEQ, 1'b1, 0, 0, "beq_taken");
        run_instr(OP_BEQ, 1'b0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_store_wait();
        run_instr(OP_STORE, 1'b0, 0, 3, "store_wait");
    endtask

    task automatic test_back_to_back();
        run_instr(OP_ITYPE, 1'b0, 2, 0, "itype_fetch_wait");
        run_instr(OP_RTYPE, 1'b1, 0, 0, "b2b_rtype");
        run_instr(OP_LOAD,  1'b0, 1, 0, "b2b_load");
        run_instr(OP_STORE, 1'b1, 0, 0, "b2b_store");
        run_instr(OP_BEQ,   1'b1, 1, 0, "b2b_beq");
    endtask

    task automatic test_illegal();
        run_instr(OP_BAD, 1'b0, 0, 0, "illegal");
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b1 || illegal4 !== 1'b1) begin
            errors++; $display("FAIL illegal_sticky got=%b/%b want=1", illegal, illegal4);
        end
        do_reset();
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b want=0", illegal); end
`else
        run_instr(OP_RTYPE, 1'b0, 0, 0, "after_nop");
        checks++;
        if (illegal !== 1'b0 || illegal4 !== 1'b0) begin
            errors++; $display("FAIL illegal_tied got=%b/%b want=0", illegal, illegal4);
        end
`endif
    endtask

    task automatic test_reset_mid_store();
        opcode = OP_STORE;
        add(P_F, 1, 0); add(P_D, 1, 0); add(P_MA, 1, 0); add(P_MW, 0, 0); add(P_MW, 0, 0);
        drain("store_pre_reset");
        mem_ready = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (bus.MemWr !== 1'b0 || bus.MemRead !== 1'b1 || bus.IorD !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL mid_store_reset memwr=%b memread=%b iord=%b retire=%b want 0 1 0 0",
                     bus.MemWr, bus.MemRead, bus.IorD, retire);
        end
        checks++;
        if (instret !== 32'd0 || instret4 !== 4'd0) begin
            errors++; $display("FAIL mid_store_instret got=%0d/%0d want=0", instret, instret4);
        end
        @(negedge clk);
        n_rst = 1'b1;
        model_cnt = 0;
        @(posedge clk); #1;
        run_instr(OP_RTYPE, 1'b0, 0, 0, "after_reset");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(OP_BEQ, 1'(i & 1), 0, 0, "wrap_beq");
        checks++;
        if (instret4 !== 4'hF) begin errors++; $display("FAIL wrap_pre got=%0d want=15", instret4); end
        run_instr(OP_BEQ, 1'b0, 0, 0, "wrap_last");
        checks++;
        if (instret4 !== 4'h0 || instret !== 32'd16) begin
            errors++; $display("FAIL wrap got=%0d/%0d want=0/16", instret4, instret);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_beq();
        test_store_wait();
        test_back_to_back();
        test_illegal();
        test_reset_mid_store();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
